// File: rtl/put_data_into_lane_pkg.sv
// Shared types and helpers for the cache lane store-merge buffer.
package put_data_into_lane_pkg;

  // Store words are 32 bits, i.e. four byte lanes per store.
  localparam int unsigned WORD_BYTES = 4;

  // Buffer control states; encodings kept identical to the legacy values.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MERGE = 2'd1,
    FLUSH = 2'd2
  } lane_state_e;

  // Number of bytes in one lane for a given geometry.
  function automatic int unsigned bytes_per_lane(input int unsigned log_sets,
                                                 input int unsigned off_bits);
    return (2 ** off_bits) * (2 ** log_sets);
  endfunction

  // Store counter increment that sticks at 8'hFF.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/put_data_into_lane_byte_select.sv
// Decodes a store's block position, word offset and byte enables into a
// per-byte write mask across the whole lane.
module lane_byte_select
  import put_data_into_lane_pkg::*;
#(
  parameter int unsigned log_of_number_of_sets = 2,
  parameter int unsigned bits_for_offset       = 3
) (
  input  logic [log_of_number_of_sets-1:0] wr_pos_i,
  input  logic [bits_for_offset-1:0]       wr_offset_i,
  input  logic [3:0]                       wr_byteenable_i,
  output logic [bytes_per_lane(log_of_number_of_sets, bits_for_offset)-1:0] byte_mask_o
);

  localparam int unsigned BYTES = bytes_per_lane(log_of_number_of_sets, bits_for_offset);
  localparam int unsigned IDXW  = log_of_number_of_sets + bits_for_offset;

  // Stores are word aligned: the two low offset bits carry no information.
  logic unused_offset_bits;
  assign unused_offset_bits = ^wr_offset_i[1:0];

  // Byte b is hit when its word index matches {pos, offset[..:2]} and the
  // enable for its position inside the word is set.
  for (genvar b = 0; b < BYTES; b++) begin : g_byte
    localparam logic [IDXW-1:0] BI = IDXW'(b);
    assign byte_mask_o[b] = (BI[IDXW-1:2] == {wr_pos_i, wr_offset_i[bits_for_offset-1:2]})
                            && wr_byteenable_i[BI[1:0]];
  end

endmodule

// File: rtl/put_data_into_lane.sv
// Cache lane store-merge buffer: loads a lane, byte-merges a burst of 32-bit
// stores into it, tracks dirty bytes and store count, then writes it back.
module put_data_into_lane #(
  parameter int unsigned log_of_number_of_sets = 2,
  parameter int unsigned bits_for_offset       = 3,
  parameter int unsigned cache_lane_size       = 8 * (2 ** bits_for_offset) * (2 ** log_of_number_of_sets)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             lane_in_valid,
  output logic                             lane_in_ready,
  input  logic [cache_lane_size-1:0]       lane_in,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [31:0]                      wr_data,
  input  logic [3:0]                       wr_byteenable,
  input  logic [bits_for_offset-1:0]       wr_offset,
  input  logic [log_of_number_of_sets-1:0] wr_pos,
  input  logic                             wr_last,
  output logic                             lane_out_valid,
  input  logic                             lane_out_ready,
  output logic [cache_lane_size-1:0]       lane_out,
  output logic [cache_lane_size/8-1:0]     dirty_mask,
  output logic [7:0]                       wr_count
);

  import put_data_into_lane_pkg::*;

  localparam int unsigned BYTES = cache_lane_size / 8;

  lane_state_e                state_q, state_d;
  logic [cache_lane_size-1:0] buf_q, buf_d;
  logic [BYTES-1:0]           dirty_q, dirty_d;
  logic [7:0]                 count_q, count_d;

  logic [BYTES-1:0]           byte_mask;
  logic [cache_lane_size-1:0] merged_lane;
  logic [BYTES-1:0]           merged_dirty;

  lane_byte_select #(
    .log_of_number_of_sets(log_of_number_of_sets),
    .bits_for_offset      (bits_for_offset)
  ) u_byte_select (
    .wr_pos_i       (wr_pos),
    .wr_offset_i    (wr_offset),
    .wr_byteenable_i(wr_byteenable),
    .byte_mask_o    (byte_mask)
  );

  // Per-byte merge: selected bytes take the matching byte of the store word.
  for (genvar b = 0; b < BYTES; b++) begin : g_merge
    assign merged_lane[8*b +: 8] = byte_mask[b] ? wr_data[8*(b % WORD_BYTES) +: 8]
                                                : buf_q[8*b +: 8];
  end
  assign merged_dirty = dirty_q | byte_mask;

  // Next-state, buffer, dirty and count update.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    dirty_d = dirty_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (lane_in_valid) begin
          buf_d   = lane_in;
          dirty_d = '0;
          count_d = '0;
          state_d = MERGE;
        end
      end
      MERGE: begin
        if (wr_valid) begin
          buf_d   = merged_lane;
          dirty_d = merged_dirty;
          count_d = sat_inc8(count_q);
          if (wr_last) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (lane_out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
      dirty_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      dirty_q <= dirty_d;
      count_q <= count_d;
    end
  end

  assign lane_in_ready  = (state_q == IDLE);
  assign wr_ready       = (state_q == MERGE);
  assign lane_out_valid = (state_q == FLUSH);
  assign lane_out       = buf_q;
  assign dirty_mask     = dirty_q;
  assign wr_count       = count_q;

endmodule

// File: tb/tb_put_data_into_lane.sv
// Scoreboard bench for put_data_into_lane: stimulus pushes the expected
// write-back lane, a negedge monitor pops and compares on each transfer.
module tb_put_data_into_lane;

  logic         clk = 1'b0;
  logic         reset;
  logic         lane_in_valid;
  logic         lane_in_ready;
  logic [255:0] lane_in;
  logic         wr_valid;
  logic         wr_ready;
  logic [31:0]  wr_data;
  logic [3:0]   wr_byteenable;
  logic [2:0]   wr_offset;
  logic [1:0]   wr_pos;
  logic         wr_last;
  logic         lane_out_valid;
  logic         lane_out_ready;
  logic [255:0] lane_out;
  logic [31:0]  dirty_mask;
  logic [7:0]   wr_count;

  always #5 clk = ~clk;

  put_data_into_lane #(
    .log_of_number_of_sets(2),
    .bits_for_offset      (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .lane_in_valid (lane_in_valid),
    .lane_in_ready (lane_in_ready),
    .lane_in       (lane_in),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_data       (wr_data),
    .wr_byteenable (wr_byteenable),
    .wr_offset     (wr_offset),
    .wr_pos        (wr_pos),
    .wr_last       (wr_last),
    .lane_out_valid(lane_out_valid),
    .lane_out_ready(lane_out_ready),
    .lane_out      (lane_out),
    .dirty_mask    (dirty_mask),
    .wr_count      (wr_count)
  );

  typedef struct {
    logic [255:0] lane;
    logic [31:0]  dirty;
    logic [7:0]   cnt;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   pushed  = 0;
  int   popped  = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [255:0] lane, input logic [31:0] dirty, input logic [7:0] cnt);
    exp_t e;
    e.lane  = lane;
    e.dirty = dirty;
    e.cnt   = cnt;
    sb.push_back(e);
    pushed++;
  endtask

  task automatic load(input logic [255:0] v);
    lane_in_valid = 1'b1;
    lane_in       = v;
    step();
    lane_in_valid = 1'b0;
  endtask

  task automatic store(input logic [1:0] pos, input logic [2:0] off, input logic [31:0] d,
                       input logic [3:0] be, input logic last);
    wr_valid      = 1'b1;
    wr_pos        = pos;
    wr_offset     = off;
    wr_data       = d;
    wr_byteenable = be;
    wr_last       = last;
    step();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!lane_in_ready && n < 100) begin
      step();
      n++;
    end
    chk("idle_timeout", 256'(lane_in_ready), 256'd1);
  endtask

  // Monitor: every write-back transfer must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && lane_out_valid && lane_out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_lane_out", 256'd1, 256'd0);
        end else begin
          e = sb.pop_front();
          popped++;
          chk("lane_out",   lane_out,          e.lane);
          chk("dirty_mask", 256'(dirty_mask),  256'(e.dirty));
          chk("wr_count",   256'(wr_count),    256'(e.cnt));
        end
      end
    end
  end

  initial begin
    logic [255:0] exp_lane;
    reset = 1'b1;
    lane_in_valid = 1'b0; lane_in = '0;
    wr_valid = 1'b0; wr_data = '0; wr_byteenable = '0; wr_offset = '0; wr_pos = '0; wr_last = 1'b0;
    lane_out_ready = 1'b1;
    repeat (3) step();
    chk("rst_lane_in_ready",  256'(lane_in_ready),  256'd1);
    chk("rst_wr_ready",       256'(wr_ready),       256'd0);
    chk("rst_lane_out_valid", 256'(lane_out_valid), 256'd0);
    chk("rst_lane_out",       lane_out,             256'd0);
    chk("rst_dirty",          256'(dirty_mask),     256'd0);
    chk("rst_count",          256'(wr_count),       256'd0);
    reset = 1'b0;
    step();

    // Test 1: full word into block 2, offset 4 -> bytes 20..23.
    exp_t1: begin
      exp_lane = {32{8'hAA}};
      exp_lane[191:160] = 32'h11223344;
      push(exp_lane, 32'h00F0_0000, 8'd1);
      load({32{8'hAA}});
      chk("merge_wr_ready", 256'(wr_ready), 256'd1);
      store(2'd2, 3'd4, 32'h11223344, 4'hF, 1'b1);
      wait_idle();
    end

    // Test 2: sparse byte enables on a zero lane.
    push({224'd0, 32'h00CC00AA}, 32'h0000_0005, 8'd1);
    load('0);
    store(2'd0, 3'd0, 32'hDDCCBBAA, 4'b0101, 1'b1);
    wait_idle();

    // Test 3: unaligned offset 5 in block 3 behaves as offset 4 -> bytes 28..31.
    exp_lane = {8{32'h12345678}};
    exp_lane[255:224] = 32'hCAFEF00D;
    push(exp_lane, 32'hF000_0000, 8'd1);
    load({8{32'h12345678}});
    store(2'd3, 3'b101, 32'hCAFEF00D, 4'hF, 1'b1);
    wait_idle();

    // Test 4: last store to a word wins; write-back held under backpressure.
    exp_lane = {8{32'h0BADF00D}};
    exp_lane[63:32] = 32'h0000_0002;
    push(exp_lane, 32'h0000_00F0, 8'd2);
    lane_out_ready = 1'b0;
    load({8{32'h0BADF00D}});
    store(2'd0, 3'd4, 32'h0000_0001, 4'hF, 1'b0);
    store(2'd0, 3'd4, 32'h0000_0002, 4'hF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 256'(lane_out_valid),  256'd1);
      chk("hold_word",  256'(lane_out[63:32]), 256'h2);
      step();
    end
    lane_out_ready = 1'b1;
    wait_idle();

    // Stray store in IDLE must not be consumed.
    wr_valid = 1'b1; wr_last = 1'b1; wr_byteenable = 4'hF; wr_data = 32'hFFFF_FFFF;
    chk("idle_wr_ready", 256'(wr_ready), 256'd0);
    step();
    wr_valid = 1'b0; wr_last = 1'b0;
    chk("idle_stays_idle", 256'(lane_in_ready), 256'd1);

    // Test 5: 300-store burst saturates the count; lane loads during MERGE ignored.
    push({248'd0, 8'h5A}, 32'h0000_0001, 8'd255);
    load('0);
    for (int i = 0; i < 300; i++) begin
      lane_in_valid = (i >= 100 && i < 200);
      lane_in       = '1;
      wr_valid      = 1'b1;
      wr_pos        = 2'd0;
      wr_offset     = 3'd0;
      wr_data       = 32'h0000_005A;
      wr_byteenable = (i == 299) ? 4'b0001 : 4'b0000;
      wr_last       = (i == 299);
      if (i == 150) chk("merge_lane_in_ready", 256'(lane_in_ready), 256'd0);
      step();
    end
    lane_in_valid = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
    wait_idle();

    // Test 6: reset in MERGE after two stores drops everything.
    load({8{32'h55AA55AA}});
    store(2'd1, 3'd0, 32'h1, 4'hF, 1'b0);
    store(2'd2, 3'd0, 32'h2, 4'hF, 1'b0);
    reset = 1'b1;
    wr_valid = 1'b1; wr_last = 1'b1;
    step();
    reset = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
    chk("mid_rst_lane_in_ready",  256'(lane_in_ready),  256'd1);
    chk("mid_rst_wr_ready",       256'(wr_ready),       256'd0);
    chk("mid_rst_lane_out_valid", 256'(lane_out_valid), 256'd0);
    chk("mid_rst_lane_out",       lane_out,             256'd0);
    chk("mid_rst_dirty",          256'(dirty_mask),     256'd0);
    chk("mid_rst_count",          256'(wr_count),       256'd0);

    repeat (3) step();
    chk("sb_drained",   256'(sb.size()), 256'd0);
    chk("sb_transfers", 256'(popped),    256'(pushed));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
